// File: rtl/pwm_out_gen_if.sv
// PWM output generator bus: register-bank configuration in, pin drive out.
// master = register bank side, slave = pwm_out_gen.
interface pwm_out_gen_if;
  logic [7:0]  en_reg_out_7_0;
  logic [7:0]  en_reg_out_15_8;
  logic [7:0]  en_reg_pwm_7_0;
  logic [7:0]  en_reg_pwm_15_8;
  logic [7:0]  pwm_duty_cycle;
  logic [15:0] out;
  logic        period_start;

  modport master (
    output en_reg_out_7_0, en_reg_out_15_8, en_reg_pwm_7_0, en_reg_pwm_15_8, pwm_duty_cycle,
    input  out, period_start
  );

  modport slave (
    input  en_reg_out_7_0, en_reg_out_15_8, en_reg_pwm_7_0, en_reg_pwm_15_8, pwm_duty_cycle,
    output out, period_start
  );
endinterface

// File: rtl/pwm_out_gen.sv
// pwm_out_gen: 16 registered drive pins, each off / on / PWM, sharing one duty
// value and one prescaled period counter.
// Optional macro PWM_SYNC_UPDATE_EN: duty is taken from a shadow register that
// only reloads at the period wrap (and on the first clk after reset), so each
// period uses exactly one duty value.
module pwm_out_gen #(
  parameter int CLK_DIV = 13,
  parameter int CNT_MAX = 254
) (
  input logic         clk,
  input logic         rst,
  pwm_out_gen_if.slave bus
);
  localparam int NUM_PINS = 16;
  localparam int PW       = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(CLK_DIV - 1);
  localparam logic [7:0]    CNT_LAST   = 8'(CNT_MAX);

  logic [PW-1:0]       presc_q, presc_d;
  logic [7:0]          cnt_q, cnt_d;
  logic                tick, wrap;
  logic                ps_q;
  logic [NUM_PINS-1:0] out_q, out_d;
  logic [NUM_PINS-1:0] en, pm;
  logic [7:0]          duty_eff;
  logic                pwm;

  assign en = {bus.en_reg_out_15_8, bus.en_reg_out_7_0};
  assign pm = {bus.en_reg_pwm_15_8, bus.en_reg_pwm_7_0};

  // Prescaler and period counter next state; cnt only moves on a tick.
  always_comb begin
    tick    = (presc_q == PRESC_LAST);
    presc_d = tick ? '0 : presc_q + PW'(1);
    wrap    = tick && (cnt_q == CNT_LAST);
    cnt_d   = cnt_q;
    if (tick) cnt_d = wrap ? 8'd0 : cnt_q + 8'd1;
  end

`ifdef PWM_SYNC_UPDATE_EN
  logic [7:0] duty_q;
  logic       first_q;

  // Duty shadow: reload on the first clk after reset and at every period wrap.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      duty_q  <= 8'h00;
      first_q <= 1'b1;
    end else begin
      first_q <= 1'b0;
      if (first_q || wrap) duty_q <= bus.pwm_duty_cycle;
    end
  end

  assign duty_eff = duty_q;
`else
  assign duty_eff = bus.pwm_duty_cycle;
`endif

  // 0xFF is forced high so full duty has no one-tick low gap.
  assign pwm = (duty_eff == 8'hFF) || (cnt_q < duty_eff);

  // Per-pin mux: enable dominates, then static-on or PWM.
  for (genvar i = 0; i < NUM_PINS; i++) begin : g_pin
    assign out_d[i] = en[i] & (~pm[i] | pwm);
  end

  // Timebase, wrap pulse and pin drive registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      presc_q <= '0;
      cnt_q   <= 8'd0;
      ps_q    <= 1'b0;
      out_q   <= '0;
    end else begin
      presc_q <= presc_d;
      cnt_q   <= cnt_d;
      ps_q    <= wrap;
      out_q   <= out_d;
    end
  end

  assign bus.out          = out_q;
  assign bus.period_start = ps_q;
endmodule
